// File: rtl/latsnq_bank.sv
// Bank of independent registered data channels with per-channel set, level or edge
// capture, sticky change flags and a shared saturating capture counter.
module latsnq_bank #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int EDGE_MODE = 0,
   parameter int CNT_W     = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS-1:0]       E,
   input  logic [CHANNELS*WIDTH-1:0] D,
   input  logic [CHANNELS-1:0]       SETN,
   input  logic [CHANNELS-1:0]       CHG_CLR,
   input  logic                      CNT_CLR,
   output logic [CHANNELS*WIDTH-1:0] Q,
   output logic [CHANNELS-1:0]       CHG,
   output logic [CNT_W-1:0]          CAP_CNT
);

   logic [CHANNELS*WIDTH-1:0] q_p0;
   logic [CHANNELS-1:0]       chg_p0;
   logic [CHANNELS-1:0]       e_p0;
   logic [CNT_W-1:0]          cnt_p0;

   logic [CHANNELS*WIDTH-1:0] q_nxt;
   logic [CHANNELS-1:0]       chg_nxt;
   logic [CHANNELS-1:0]       cap;
   logic                      any_cap;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A forced set takes priority, so a rising edge that coincides with SETN low
   // is consumed: e_p0 still records E and no later capture happens for it.
   always_comb begin
      if (EDGE_MODE != 0)
         cap = E & SETN & ~e_p0;
      else
         cap = E & SETN;
      any_cap = |cap;
      q_nxt   = q_p0;
      chg_nxt = chg_p0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (!SETN[k])
            q_nxt[k*WIDTH +: WIDTH] = '1;
         else if (cap[k])
            q_nxt[k*WIDTH +: WIDTH] = D[k*WIDTH +: WIDTH];
         if (CHG_CLR[k])
            chg_nxt[k] = 1'b0;
         if (q_nxt[k*WIDTH +: WIDTH] != q_p0[k*WIDTH +: WIDTH])
            chg_nxt[k] = 1'b1;
      end
   end

   // Stage p0: single register stage feeding every output
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_p0   <= '0;
         chg_p0 <= '0;
         e_p0   <= '0;
         cnt_p0 <= '0;
      end else begin
         q_p0   <= q_nxt;
         chg_p0 <= chg_nxt;
         e_p0   <= E;
         if (CNT_CLR)
            cnt_p0 <= '0;
         else if (any_cap)
            cnt_p0 <= sat_inc(cnt_p0);
      end
   end

   assign Q       = q_p0;
   assign CHG     = chg_p0;
   assign CAP_CNT = cnt_p0;

endmodule

// File: tb/tb_latsnq_bank.sv
// Directed bench for latsnq_bank: level-mode, edge-mode and 2-bit-counter instances
// share one stimulus stream; each phase checks the instance it exercises.
module tb_latsnq_bank;

   logic        CLK = 1'b0;
   logic        RST;
   logic [3:0]  E;
   logic [31:0] D;
   logic [3:0]  SETN;
   logic [3:0]  CHG_CLR;
   logic        CNT_CLR;

   logic [31:0] q_l, q_e, q_c;
   logic [3:0]  chg_l, chg_e, chg_c;
   logic [7:0]  cnt_l, cnt_e;
   logic [1:0]  cnt_c;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   latsnq_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(0), .CNT_W(8)) u_lvl (
      .CLK(CLK), .RST(RST), .E(E), .D(D), .SETN(SETN), .CHG_CLR(CHG_CLR),
      .CNT_CLR(CNT_CLR), .Q(q_l), .CHG(chg_l), .CAP_CNT(cnt_l));

   latsnq_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(1), .CNT_W(8)) u_edge (
      .CLK(CLK), .RST(RST), .E(E), .D(D), .SETN(SETN), .CHG_CLR(CHG_CLR),
      .CNT_CLR(CNT_CLR), .Q(q_e), .CHG(chg_e), .CAP_CNT(cnt_e));

   latsnq_bank #(.WIDTH(8), .CHANNELS(4), .EDGE_MODE(0), .CNT_W(2)) u_c2 (
      .CLK(CLK), .RST(RST), .E(E), .D(D), .SETN(SETN), .CHG_CLR(CHG_CLR),
      .CNT_CLR(CNT_CLR), .Q(q_c), .CHG(chg_c), .CAP_CNT(cnt_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      RST = 1'b0; E = 4'b0000; D = 32'h0; SETN = 4'b1111; CHG_CLR = 4'b0000; CNT_CLR = 1'b0;
   endtask

   initial begin
      idle();
      #1;

      // Reset overrides set, enable, clears
      RST = 1'b1; E = 4'b1111; SETN = 4'b0000; CHG_CLR = 4'b1111; CNT_CLR = 1'b1; D = 32'hDEADBEEF;
      tick();
      chk("rst_q", q_l, 32'h0);
      chk("rst_chg", {28'h0, chg_l}, 32'h0);
      chk("rst_cnt", {24'h0, cnt_l}, 32'h0);
      chk("rst_q_edge", q_e, 32'h0);

      // Level capture ch0
      idle(); E = 4'b0001; D = 32'h000000A5;
      tick();
      chk("lvl_cap_q", q_l, 32'h000000A5);
      chk("lvl_cap_chg", {28'h0, chg_l}, 32'h1);
      chk("lvl_cap_cnt", {24'h0, cnt_l}, 32'd1);

      // Set ch1 beats its capture, no count
      idle(); SETN = 4'b1101; E = 4'b0010; D = 32'h00003C00;
      tick();
      chk("set_q", q_l, 32'h0000FFA5);
      chk("set_chg", {28'h0, chg_l}, 32'h3);
      chk("set_cnt", {24'h0, cnt_l}, 32'd1);

      // Same-value capture with CHG_CLR clears the flag, still counts
      idle(); E = 4'b0001; D = 32'h000000A5; CHG_CLR = 4'b0001;
      tick();
      chk("same_q", q_l, 32'h0000FFA5);
      chk("same_chg", {28'h0, chg_l}, 32'h2);
      chk("same_cnt", {24'h0, cnt_l}, 32'd2);

      // Changed value with CHG_CLR keeps the flag set
      idle(); E = 4'b0001; D = 32'h0000005A; CHG_CLR = 4'b0001;
      tick();
      chk("diff_q", q_l, 32'h0000FF5A);
      chk("diff_chg", {28'h0, chg_l}, 32'h3);
      chk("diff_cnt", {24'h0, cnt_l}, 32'd3);

      // Two channels capturing count once
      idle(); E = 4'b1100; D = 32'h11220000;
      tick();
      chk("multi_q", q_l, 32'h1122FF5A);
      chk("multi_chg", {28'h0, chg_l}, 32'hF);
      chk("multi_cnt", {24'h0, cnt_l}, 32'd4);

      // Clear all flags while ch0 is set; CNT_CLR beats a capture
      idle(); SETN = 4'b1110; CHG_CLR = 4'b1111; CNT_CLR = 1'b1; E = 4'b0100; D = 32'h00220000;
      tick();
      chk("clr_q", q_l, 32'h1122FFFF);
      chk("clr_chg", {28'h0, chg_l}, 32'h1);
      chk("clr_cnt", {24'h0, cnt_l}, 32'd0);

      // Mid-stream reset; E[2] held high through release for the edge instance
      idle(); RST = 1'b1; E = 4'b0100; D = 32'hFFFFFFFF;
      tick();
      chk("mid_rst_q", q_l, 32'h0);
      chk("mid_rst_chg", {28'h0, chg_l}, 32'h0);
      chk("mid_rst_cnt", {24'h0, cnt_l}, 32'd0);

      // Edge mode: held E counts as a rising edge right after reset
      idle(); E = 4'b0100; D = 32'h00100000;
      tick();
      chk("edge_first_q", q_e, 32'h00100000);
      chk("edge_first_chg", {28'h0, chg_e}, 32'h4);
      chk("edge_first_cnt", {24'h0, cnt_e}, 32'd1);

      // E[2] stays high while D changes: no further capture
      for (int i = 2; i <= 5; i++) begin
         E = 4'b0100; D = {8'h00, 4'(i), 4'h0, 16'h0000};
         tick();
         chk("edge_hold_q", q_e, 32'h00100000);
      end
      chk("edge_hold_cnt", {24'h0, cnt_e}, 32'd1);

      // Rising edge on ch0 during set is consumed
      idle();
      tick();
      E = 4'b0001; SETN = 4'b1110; D = 32'h00000077;
      tick();
      chk("edge_set_q", q_e, 32'h001000FF);
      SETN = 4'b1111;
      tick();
      chk("edge_rel_q", q_e, 32'h001000FF);
      chk("edge_rel_cnt", {24'h0, cnt_e}, 32'd1);
      E = 4'b0000;
      tick();
      chk("edge_low_q", q_e, 32'h001000FF);
      E = 4'b0001;
      tick();
      chk("edge_rerise_q", q_e, 32'h00100077);
      chk("edge_rerise_cnt", {24'h0, cnt_e}, 32'd2);

      // 2-bit counter saturation and clear
      idle(); RST = 1'b1;
      tick();
      chk("c2_rst_cnt", {30'h0, cnt_c}, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         idle(); E = 4'b0001; D = 32'(i);
         tick();
         chk("c2_sat_cnt", {30'h0, cnt_c}, (i < 3) ? 32'(i) : 32'd3);
      end
      chk("c2_q", q_c, 32'h00000005);
      idle(); E = 4'b0001; D = 32'h00000006; CNT_CLR = 1'b1;
      tick();
      chk("c2_clr_cnt", {30'h0, cnt_c}, 32'd0);
      chk("c2_clr_q", q_c, 32'h00000006);

      idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/latsnq_bank.md
LATSNQ_BANK -- requirements
Module: latsnq_bank

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (1..32).
REQ-002 Parameter CHANNELS, default 4, number of independent storage channels (1..16).
REQ-003 Parameter EDGE_MODE, default 0: 0 = level capture, 1 = rising-edge-of-E capture.
REQ-004 Parameter CNT_W, default 8, capture-counter width (2..16).
REQ-005 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-006 CLK  input  1  clock; all state updates on rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 E  input  CHANNELS  per-channel capture enable.
REQ-009 D  input  CHANNELS*WIDTH  channel data, channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SETN  input  CHANNELS  per-channel active-low synchronous set.
REQ-011 CHG_CLR  input  CHANNELS  per-channel clear of the change flag.
REQ-012 CNT_CLR  input  1  clear of the capture counter.
REQ-013 Q  output  CHANNELS*WIDTH  stored channel data, same packing as D.
REQ-014 CHG  output  CHANNELS  sticky per-channel "Q changed" flag.
REQ-015 CAP_CNT  output  CNT_W  saturating count of capture cycles.

Function
REQ-016 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-017 Per-channel priority each cycle SHALL be: RST, then SETN low, then capture, then hold.
REQ-018 When SETN[k]=0 and RST=0, Q channel k SHALL become all-ones on the next edge, regardless of E[k].
REQ-019 Level mode: when E[k]=1 and SETN[k]=1, Q channel k SHALL load D channel k on the next edge (1-cycle latency).
REQ-020 Edge mode: channel k SHALL capture only in a cycle where E[k]=1, registered previous E[k]=0, and SETN[k]=1.
REQ-021 Edge mode: a rising edge of E[k] coinciding with SETN[k]=0 SHALL be consumed; there is no capture after SETN release until a new 0->1 transition of E[k].
REQ-022 The previous-E register SHALL update every cycle, including cycles with SETN low, and SHALL reset to 0.
REQ-023 CHG[k] SHALL be set on the edge where channel k's Q value actually changes (by set or capture); an equal-value capture SHALL NOT set it.
REQ-024 CHG_CLR[k]=1 SHALL clear CHG[k]; when a set event occurs in the same cycle, CHG[k] SHALL end at 1.
REQ-025 CAP_CNT SHALL increment by exactly 1 in any cycle where at least one channel captures (SETN-forced sets do not count), whatever the number of capturing channels.
REQ-026 CAP_CNT SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 CNT_CLR=1 SHALL force CAP_CNT to 0 and SHALL override a simultaneous increment.
REQ-028 Channels SHALL be fully independent: no channel's inputs affect another channel's Q or CHG.

Reset
REQ-029 With RST=1 on an edge: Q SHALL be all-zeros, CHG SHALL be 0, CAP_CNT SHALL be 0, and the previous-E register SHALL be 0; RST overrides SETN, E, CHG_CLR and CNT_CLR.
REQ-030 RST asserted mid-operation SHALL take effect on the next edge with no residual state; the first post-reset cycle behaves as after power-up.
REQ-031 In edge mode, E[k] held at 1 through reset release SHALL count as a rising edge in the first cycle after RST deasserts.

Verification
REQ-032 Level mode, defaults: RST, then E=4'b0001, D ch0=8'hA5 -> next cycle Q ch0=8'hA5, CHG=4'b0001, CAP_CNT=1; other channels stay 8'h00.
REQ-033 SETN=4'b1101 with E=4'b0010, D ch1=8'h3C -> Q ch1=8'hFF, CHG[1]=1, CAP_CNT unchanged.
REQ-034 Edge mode: E[2] held at 1 for 5 cycles with D changing each cycle -> Q ch2 holds the first-cycle value only, and CAP_CNT increments once.
REQ-035 Edge mode: E[0] rises during SETN[0]=0, SETN releases while E[0] is still 1 -> Q ch0 stays 8'hFF until E[0] drops and rises again.
REQ-036 CNT_W=2: capture on 5 consecutive cycles -> CAP_CNT goes 1,2,3,3,3; CNT_CLR together with a capture -> 0.
REQ-037 Capture of the same value with CHG_CLR=1 -> CHG=0; changed value with CHG_CLR=1 -> CHG=1; RST mid-stream -> all outputs 0 next cycle.
